// File: rtl/fast_square_bin_accum.sv
// -----------------------------------------------------------------------------
// fast_square_bin_accum
//
// Purpose: integrates fast-square I/Q samples per frequency bin.
// freq_step closes the current bin. The closed bin is streamed toward
// rx_buffer as three 16-bit word pairs:
//   header : {bin index, sample count}
//   high   : upper halves of the I/Q sums
//   low    : lower halves of the I/Q sums
//
// Handshake: out_strobe is a pacing pulse with no back-pressure. Each pulse
// accepted while a bin is pending produces exactly one word pair. That pair
// appears one cycle later, qualified by a single-cycle out_valid. When a
// strobe is not accepted, out_valid stays low and i_out/q_out hold.
//
// Optional feature: define FAST_SQUARE_SATURATE_EN so that the accumulators
// clamp at the signed limits. Without it they wrap.
//
// Ports:
//   clock, reset_n     sample clock (clk64 domain), async active-low reset
//   i_in, q_in         signed samples, qualified by in_strobe
//   record             accumulate gate
//   freq_step          closes the current bin and advances the bin index
//   sweep_reset        restarts the sweep at bin 0 and discards partial sums
//   out_strobe         downstream pacing, one word pair per pulse
//   clear_status       clears the sticky overrun flag
//   i_out, q_out       registered output word pair
//   out_valid          one-cycle qualifier for i_out/q_out
//   overrun            sticky flag, set when a closed bin was dropped
//   busy               a closed bin is pending or being emitted
//   dbg_state          emitter FSM state (0 IDLE, 1 HDR, 2 HI, 3 LO)
// -----------------------------------------------------------------------------
module fast_square_bin_accum #(
    parameter int NUM_FREQ_STEPS = 37,
    parameter int ACC_WIDTH      = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic signed [15:0] i_in,
    input  logic signed [15:0] q_in,
    input  logic               in_strobe,
    input  logic               record,
    input  logic               freq_step,
    input  logic               sweep_reset,
    input  logic               out_strobe,
    input  logic               clear_status,
    output logic        [15:0] i_out,
    output logic        [15:0] q_out,
    output logic               out_valid,
    output logic               overrun,
    output logic               busy,
    output logic        [1:0]  dbg_state
);

    localparam int AW = ACC_WIDTH;
    localparam logic [7:0] BIN_LAST = 8'(NUM_FREQ_STEPS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, HI = 2'd2, LO = 2'd3} emit_state_t;

    emit_state_t state_q, state_d;

    logic signed [AW-1:0] acc_i, acc_q, sum_i, sum_q;
    logic signed [AW-1:0] hold_i, hold_q;
    logic        [15:0]   count, count_nxt, hold_cnt;
    logic        [7:0]    bin_idx, hold_bin;
    logic        [31:0]   hold_i32, hold_q32;
    logic                 sample_ok, close_bin, set_ovr, emit;
    logic        [15:0]   word_i, word_q;

    // One extra bit of headroom exposes signed overflow of the add.
    function automatic logic signed [AW-1:0] add_sample(input logic signed [AW-1:0] acc,
                                                       input logic signed [15:0]   s);
        logic [AW:0] wide;
        wide = {acc[AW-1], acc} + {{(AW+1-16){s[15]}}, s};
`ifdef FAST_SQUARE_SATURATE_EN
        if (wide[AW] != wide[AW-1]) begin
            return wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end
`endif
        return wide[AW-1:0];
    endfunction

    assign sample_ok = in_strobe & record;
    // A qualifying sample on the closing cycle is counted in the closed bin,
    // so the captured values are the post-add sums, not the current registers.
    assign sum_i     = sample_ok ? add_sample(acc_i, i_in) : acc_i;
    assign sum_q     = sample_ok ? add_sample(acc_q, q_in) : acc_q;
    assign count_nxt = (sample_ok && count != 16'hFFFF) ? count + 16'd1 : count;

    // sweep_reset masks a coincident freq_step completely.
    assign close_bin = freq_step & ~sweep_reset;
    assign set_ovr   = close_bin & (state_q != IDLE);

    assign hold_i32  = 32'(hold_i);
    assign hold_q32  = 32'(hold_q);
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        word_i  = '0;
        word_q  = '0;
        case (state_q)
            IDLE: if (close_bin) state_d = HDR;
            HDR: if (out_strobe) begin
                emit    = 1'b1;
                word_i  = {8'h00, hold_bin};
                word_q  = hold_cnt;
                state_d = HI;
            end
            HI: if (out_strobe) begin
                emit    = 1'b1;
                word_i  = hold_i32[31:16];
                word_q  = hold_q32[31:16];
                state_d = LO;
            end
            LO: if (out_strobe) begin
                emit    = 1'b1;
                word_i  = hold_i32[15:0];
                word_q  = hold_q32[15:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_i     <= '0;
            acc_q     <= '0;
            count     <= '0;
            bin_idx   <= '0;
            hold_i    <= '0;
            hold_q    <= '0;
            hold_cnt  <= '0;
            hold_bin  <= '0;
            overrun   <= 1'b0;
            out_valid <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
        end else begin
            if (sweep_reset) begin
                acc_i   <= '0;
                acc_q   <= '0;
                count   <= '0;
                bin_idx <= '0;
            end else if (freq_step) begin
                acc_i   <= '0;
                acc_q   <= '0;
                count   <= '0;
                bin_idx <= (bin_idx == BIN_LAST) ? 8'd0 : bin_idx + 8'd1;
                // A bin closed while the emitter is busy is dropped (see set_ovr).
                if (state_q == IDLE) begin
                    hold_i   <= sum_i;
                    hold_q   <= sum_q;
                    hold_cnt <= count_nxt;
                    hold_bin <= bin_idx;
                end
            end else begin
                acc_i <= sum_i;
                acc_q <= sum_q;
                count <= count_nxt;
            end

            if (set_ovr)           overrun <= 1'b1;
            else if (clear_status) overrun <= 1'b0;

            out_valid <= emit;
            if (emit) begin
                i_out <= word_i;
                q_out <= word_q;
            end
        end
    end

endmodule
